// File: rtl/mem_stage_ldext.sv
// mem_stage_ldext: pipeline memory stage holding one instruction.
// Waits for a variable-latency data-SRAM response, aligns and extends
// sub-word loads, buffers the response while writeback stalls and
// exports a forwarding bus with a load-pending flag for hazard detection.
// Optional build macro MEM_STAGE_FLUSH_EN adds the ms_flush input and the
// late-response discard flag.
module mem_stage_ldext #(
   parameter int REG_ADDR_W = 5,
   parameter int PC_W       = 32,
   parameter int HOLD_RDATA = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ws_allowin,
   output logic                         ms_allowin,
   input  logic                         es_to_ms_valid,
   input  logic [PC_W+REG_ADDR_W+37:0]  es_to_ms_bus,
   output logic                         ms_to_ws_valid,
   output logic [PC_W+REG_ADDR_W+32:0]  ms_to_ws_bus,
   input  logic                         data_sram_data_ok,
   input  logic [31:0]                  data_sram_rdata,
`ifdef MEM_STAGE_FLUSH_EN
   input  logic                         ms_flush,
`endif
   output logic [REG_ADDR_W+33:0]       ms_to_ds_bus
);

   localparam int BUS_W = PC_W + REG_ADDR_W + 38;

   // Field offsets inside the execute->memory bus.
   localparam int ALU_LSB  = PC_W;
   localparam int DEST_LSB = PC_W + 32;
   localparam int WE_BIT   = PC_W + REG_ADDR_W + 32;
   localparam int RES_BIT  = PC_W + REG_ADDR_W + 33;
   localparam int OP_LSB   = PC_W + REG_ADDR_W + 34;
   localparam int REQ_BIT  = PC_W + REG_ADDR_W + 37;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [BUS_W-1:0]        r_bus;

   logic                    w_flush;
   logic                    w_resp;
   logic                    w_ms_valid;
   logic                    w_resp_got;
   logic                    w_ready_go;
   logic                    w_allowin;

   logic [PC_W-1:0]         w_pc_r;
   logic [31:0]             w_alu_r;
   logic [REG_ADDR_W-1:0]   w_dest_r;
   logic                    w_gr_we_r;
   logic                    w_res_from_mem_r;
   logic [2:0]              w_ld_op_r;
   logic                    w_mem_req_r;

   logic [31:0]             w_raw;
   logic [1:0]              w_off;
   logic [7:0]              w_lane [4];
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [31:0]             w_extracted;
   logic [31:0]             w_final_result;

   assign w_pc_r           = r_bus[PC_W-1:0];
   assign w_alu_r          = r_bus[ALU_LSB +: 32];
   assign w_dest_r         = r_bus[DEST_LSB +: REG_ADDR_W];
   assign w_gr_we_r        = r_bus[WE_BIT];
   assign w_res_from_mem_r = r_bus[RES_BIT];
   assign w_ld_op_r        = r_bus[OP_LSB +: 3];
   assign w_mem_req_r      = r_bus[REQ_BIT];

`ifdef MEM_STAGE_FLUSH_EN
   logic r_discard;

   assign w_flush = ms_flush;
   // A response belonging to a flushed instruction must never be taken
   // by whatever instruction occupies the stage when it arrives.
   assign w_resp  = data_sram_data_ok && !r_discard;

   // Discard flag: armed when a flush abandons an outstanding request,
   // cleared by the next data_ok (which is dropped).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_discard <= 1'b0;
      end else begin
         r_discard <= (r_discard && !data_sram_data_ok) ||
                      (ms_flush && (r_state == ST_WAIT) && !w_resp);
      end
   end
`else
   assign w_flush = 1'b0;
   assign w_resp  = data_sram_data_ok;
`endif

   assign w_ms_valid = (r_state != ST_EMPTY);
   // Entering WAIT clears the response flag; READY with a memory request
   // means the response has already been captured.
   assign w_resp_got = (r_state == ST_READY) && w_mem_req_r;
   assign w_ready_go = !w_mem_req_r || w_resp_got || w_resp;
   assign w_allowin  = !w_flush && (!w_ms_valid || (w_ready_go && ws_allowin));

   // State register; stray responses in EMPTY/READY have no effect.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: flush empties, accept loads a new instruction, response
   // moves WAIT to READY while writeback is stalled.
   always_comb begin
      w_state_next = r_state;
      if (w_flush) begin
         w_state_next = ST_EMPTY;
      end else if (w_allowin) begin
         if (es_to_ms_valid) begin
            w_state_next = es_to_ms_bus[REQ_BIT] ? ST_WAIT : ST_READY;
         end else begin
            w_state_next = ST_EMPTY;
         end
      end else if ((r_state == ST_WAIT) && w_resp) begin
         w_state_next = ST_READY;
      end
   end

   // Instruction payload register, loaded only on an actual handoff.
   always_ff @(posedge clk) begin
      if (es_to_ms_valid && w_allowin) begin
         r_bus <= es_to_ms_bus;
      end
   end

   generate
      if (HOLD_RDATA != 0) begin : g_buf
         logic [31:0] r_rdata_buf;

         // Capture the response so the stage can hold it across a stall.
         always_ff @(posedge clk) begin
            if ((r_state == ST_WAIT) && w_resp) begin
               r_rdata_buf <= data_sram_rdata;
            end
         end

         assign w_raw = w_resp_got ? r_rdata_buf : data_sram_rdata;
      end else begin : g_nobuf
         // Upstream keeps rdata stable until the stage advances.
         assign w_raw = data_sram_rdata;
      end
   endgenerate

   assign w_off = w_alu_r[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane[gi] = w_raw[8*gi +: 8];
      end
   endgenerate

   assign w_byte = w_lane[w_off];
   assign w_half = w_off[1] ? w_raw[31:16] : w_raw[15:0];

   // Sub-word alignment and sign/zero extension; unused encodings act as lw.
   always_comb begin
      w_extracted = w_raw;
      case (w_ld_op_r)
         3'b001:  w_extracted = {{24{w_byte[7]}}, w_byte};
         3'b010:  w_extracted = {24'd0, w_byte};
         3'b011:  w_extracted = {{16{w_half[15]}}, w_half};
         3'b100:  w_extracted = {16'd0, w_half};
         default: w_extracted = w_raw;
      endcase
   end

   assign w_final_result = w_res_from_mem_r ? w_extracted : w_alu_r;

   assign ms_allowin     = w_allowin;
   assign ms_to_ws_valid = w_ms_valid && w_ready_go && !w_flush;
   assign ms_to_ws_bus   = {w_gr_we_r, w_dest_r, w_final_result, w_pc_r};
   assign ms_to_ds_bus   = {w_ms_valid && w_res_from_mem_r && !w_ready_go,
                            w_ms_valid && w_gr_we_r,
                            w_dest_r,
                            w_final_result};

endmodule

// File: tb/tb_mem_stage_ldext.sv
// Testbench for mem_stage_ldext: directed cases, randomized traffic with a
// behavioural load model, a writeback scoreboard and a reset-in-WAIT check.
module tb_mem_stage_ldext;

   localparam int RA  = 5;
   localparam int PW  = 32;
   localparam int ESW = PW + RA + 38;
   localparam int WSW = PW + RA + 33;
   localparam int DSW = RA + 34;
   localparam int N_RANDOM = 300;

   logic            clk = 1'b0;
   logic            reset;
   logic            ws_allowin;
   logic            ms_allowin;
   logic            es_to_ms_valid;
   logic [ESW-1:0]  es_to_ms_bus;
   logic            ms_to_ws_valid;
   logic [WSW-1:0]  ms_to_ws_bus;
   logic            data_sram_data_ok;
   logic [31:0]     data_sram_rdata;
   logic [DSW-1:0]  ms_to_ds_bus;
`ifdef MEM_STAGE_FLUSH_EN
   logic            ms_flush = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_stage_ldext #(.REG_ADDR_W(RA), .PC_W(PW), .HOLD_RDATA(1)) dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
`ifdef MEM_STAGE_FLUSH_EN
      .ms_flush          (ms_flush),
`endif
      .ms_to_ds_bus      (ms_to_ds_bus)
   );

   typedef struct {
      bit        mem_req;
      bit [2:0]  ld_op;
      bit        res;
      bit        gr_we;
      bit [4:0]  dest;
      bit [31:0] alu;
      bit [31:0] pc;
      bit [31:0] rdata;
      int        lat;
      int        stall;
      bit        use_exp;
      bit [31:0] exp;
   } instr_t;

   int errors = 0;
   int checks = 0;

   logic [WSW-1:0] sb_q[$];
   instr_t         dir_tab[$];
   int             dir_idx = 0;
   int             phase = 0;
   int             n_issued = 0;

   // Behavioural view of the stage and the memory
   bit        occ = 0;
   bit        resp_done = 0;
   instr_t    cur;
   bit        outstanding = 0;
   int        wait_cnt = 0;
   bit [31:0] out_rdata = 0;
   int        stall_cnt = 0;
   bit        have_offer = 0;
   instr_t    offer;

   // Load result from the instruction's rules, using plain arithmetic.
   function automatic bit [31:0] ref_result(instr_t t);
      int        off;
      bit [7:0]  b;
      bit [15:0] h;
      off = int'(t.alu % 4);
      b   = 8'((t.rdata >> (8 * off)) & 32'hFF);
      h   = 16'((t.rdata >> (16 * (off / 2))) & 32'hFFFF);
      if (!t.res) return t.alu;
      case (t.ld_op)
         3'd1: return (b >= 8'd128) ? 32'(int'(b) - 256) : 32'(b);
         3'd2: return 32'(b);
         3'd3: return (h >= 16'd32768) ? 32'(int'(h) - 65536) : 32'(h);
         3'd4: return 32'(h);
         default: return t.rdata;
      endcase
   endfunction

   function automatic logic [ESW-1:0] pack_es(instr_t t);
      return {t.mem_req, t.ld_op, t.res, t.gr_we, t.dest, t.alu, t.pc};
   endfunction

   function automatic logic [WSW-1:0] pack_ws(instr_t t);
      bit [31:0] r;
      r = t.use_exp ? t.exp : ref_result(t);
      return {t.gr_we, t.dest, r, t.pc};
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      t.mem_req = 1'($urandom_range(0, 1));
      t.res     = t.mem_req && ($urandom_range(0, 3) != 0);
      t.ld_op   = 3'($urandom_range(0, 7));
      t.gr_we   = 1'($urandom_range(0, 1));
      t.dest    = 5'($urandom_range(0, 31));
      t.alu     = $urandom;
      t.pc      = $urandom;
      t.rdata   = $urandom;
      t.lat     = $urandom_range(0, 4);
      t.stall   = 0;
      t.use_exp = 0;
      t.exp     = 0;
      return t;
   endfunction

   function automatic instr_t mk(bit mreq, bit [2:0] op, bit res, bit [31:0] alu,
                                 bit [31:0] rd, int lat, int stall, bit [31:0] exp);
      instr_t t;
      t.mem_req = mreq; t.ld_op = op; t.res = res; t.gr_we = 1'b1;
      t.dest = 5'($urandom_range(1, 31)); t.alu = alu; t.pc = $urandom;
      t.rdata = rd; t.lat = lat; t.stall = stall; t.use_exp = 1'b1; t.exp = exp;
      return t;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit drained();
      bit src_done;
      src_done = (phase == 0) ? (dir_idx >= dir_tab.size()) : (n_issued >= N_RANDOM);
      return src_done && !have_offer && !occ && (sb_q.size() == 0);
   endfunction

   // One clock cycle: drive memory, writeback and execute sides, check the
   // stage's combinational outputs against the model, then advance the model.
   task automatic do_cycle();
      bit real_ok;
      bit stray;
      bit exp_ready;
      bit exp_allow;
      bit exp_ldp;
      @(negedge clk);
      real_ok = 0;
      stray   = 0;
      if (outstanding) begin
         if (wait_cnt == 0) begin
            real_ok     = 1;
            outstanding = 0;
         end else begin
            wait_cnt--;
         end
      end else if (phase == 1 && $urandom_range(0, 7) == 0) begin
         stray = 1;
      end
      data_sram_data_ok = real_ok || stray;
      data_sram_rdata   = real_ok ? out_rdata : $urandom;

      if (real_ok && cur.stall > 0) stall_cnt = cur.stall;
      if (stall_cnt > 0) begin
         ws_allowin = 1'b0;
         stall_cnt--;
      end else begin
         ws_allowin = (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end

      if (!have_offer) begin
         if (phase == 0 && dir_idx < dir_tab.size()) begin
            offer = dir_tab[dir_idx];
            dir_idx++;
            have_offer = 1;
         end else if (phase == 1 && n_issued < N_RANDOM && $urandom_range(0, 3) != 0) begin
            offer = rand_instr();
            have_offer = 1;
         end
      end
      es_to_ms_valid = have_offer;
      es_to_ms_bus   = have_offer ? pack_es(offer) : ESW'({$urandom, $urandom, $urandom});

      #1;
      exp_ready = occ && (!cur.mem_req || resp_done || real_ok);
      exp_allow = !occ || (exp_ready && ws_allowin);
      exp_ldp   = occ && cur.res && !exp_ready;
      check("ms_allowin", 32'(ms_allowin), 32'(exp_allow));
      check("ms_to_ws_valid", 32'(ms_to_ws_valid), 32'(exp_ready));
      check("ds_we", 32'(ms_to_ds_bus[DSW-2]), 32'(occ && cur.gr_we));
      check("ld_pending", 32'(ms_to_ds_bus[DSW-1]), 32'(exp_ldp));
      if (occ && !exp_ldp) begin
         check("ds_final_result", ms_to_ds_bus[31:0],
               cur.use_exp ? cur.exp : ref_result(cur));
      end

      if (occ && exp_ready && ws_allowin) occ = 0;
      if (occ && real_ok) resp_done = 1;
      if (have_offer && exp_allow) begin
         occ        = 1;
         cur        = offer;
         resp_done  = 0;
         have_offer = 0;
         sb_q.push_back(pack_ws(offer));
         n_issued++;
         if (offer.mem_req) begin
            outstanding = 1;
            wait_cnt    = offer.lat;
            out_rdata   = offer.rdata;
         end
      end
   endtask

   task automatic run_until_drained(int budget, string name);
      int c = 0;
      while (!drained() && c < budget) begin
         do_cycle();
         c++;
      end
      checks++;
      if (!drained()) begin
         errors++;
         $display("FAIL %s: not drained after %0d cycles, %0d entries left", name, c, sb_q.size());
      end
   endtask

   // Monitor: every writeback handoff pops the oldest expected entry.
   initial begin
      logic [WSW-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL ws_unexpected: got %h, expected no transfer", ms_to_ws_bus);
            end else begin
               e = sb_q.pop_front();
               if (ms_to_ws_bus !== e) begin
                  errors++;
                  $display("FAIL ws_bus: got %h, expected %h", ms_to_ws_bus, e);
               end else begin
                  $display("ws xfer pc=%h we=%0d dest=%0d result=%h",
                           ms_to_ws_bus[31:0], ms_to_ws_bus[WSW-1],
                           ms_to_ws_bus[WSW-2 -: RA], ms_to_ws_bus[63:32]);
               end
            end
         end
      end
   end

   initial begin
      reset             = 1'b1;
      ws_allowin        = 1'b0;
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;

      dir_tab.push_back(mk(0, 3'd0, 0, 32'h12345678, 32'h0,        0, 0, 32'h12345678));
      dir_tab.push_back(mk(1, 3'd1, 1, 32'h00000102, 32'h00800000, 3, 0, 32'hFFFFFF80));
      dir_tab.push_back(mk(1, 3'd4, 1, 32'h00000206, 32'hBEEF0000, 1, 4, 32'h0000BEEF));
      dir_tab.push_back(mk(1, 3'd0, 1, 32'h00000100, 32'h11111111, 0, 0, 32'h11111111));
      dir_tab.push_back(mk(1, 3'd0, 1, 32'h00000104, 32'h22222222, 0, 0, 32'h22222222));
      dir_tab.push_back(mk(1, 3'd3, 1, 32'h00000000, 32'h12348001, 2, 2, 32'hFFFF8001));

      repeat (3) @(negedge clk);
      check("reset_ws_valid", 32'(ms_to_ws_valid), 32'd0);
      check("reset_allowin", 32'(ms_allowin), 32'd1);
      check("reset_ds_we", 32'(ms_to_ds_bus[DSW-2]), 32'd0);
      check("reset_ld_pending", 32'(ms_to_ds_bus[DSW-1]), 32'd0);
      reset = 1'b0;

      phase = 0;
      run_until_drained(200, "directed_drain");

      phase = 1;
      run_until_drained(20000, "random_drain");

      // Reset while a load waits for its response.
      phase = 0;
      dir_tab.push_back(mk(1, 3'd0, 1, 32'h00000010, 32'hA5A5A5A5, 1000, 0, 32'hA5A5A5A5));
      begin
         int c = 0;
         while (!(occ && outstanding) && c < 20) begin
            do_cycle();
            c++;
         end
      end
      do_cycle();
      do_cycle();
      @(negedge clk);
      reset             = 1'b1;
      ws_allowin        = 1'b0;
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      check("rst_wait_ws_valid", 32'(ms_to_ws_valid), 32'd0);
      check("rst_wait_ld_pending", 32'(ms_to_ds_bus[DSW-1]), 32'd0);
      check("rst_wait_allowin", 32'(ms_allowin), 32'd1);
      check("rst_wait_ds_we", 32'(ms_to_ds_bus[DSW-2]), 32'd0);
      sb_q.delete();
      occ = 0; outstanding = 0; have_offer = 0; resp_done = 0; stall_cnt = 0;
      reset = 1'b0;

      // Stage is usable again after the reset.
      dir_tab.push_back(mk(1, 3'd2, 1, 32'h00000003, 32'h9C000000, 1, 1, 32'h0000009C));
      run_until_drained(50, "post_reset_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_ldext.md
Name: mem_stage_ldext

Overview:
Parametrised successor of the pipeline memory stage. It sits between the execute and writeback stages, holds one instruction, and waits for a variable-latency data-SRAM response. It aligns and sign/zero-extends sub-word loads, buffers the response while writeback stalls, and exports a forwarding bus with a load-pending flag so decode can detect load-use hazards.

Parameters:
REG_ADDR_W, 5, destination register index width
PC_W, 32, PC width
HOLD_RDATA, 1, 1 = latch early response in a local buffer; 0 = no buffer; upstream then guarantees rdata stays stable until the stage advances

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
ws_allowin  in  1  writeback can accept
ms_allowin  out  1  this stage can accept
es_to_ms_valid  in  1  execute output valid
es_to_ms_bus  in  PC_W+REG_ADDR_W+38  {mem_req, ld_op[2:0], res_from_mem, gr_we, dest, alu_result[31:0], pc}, MSB first
ms_to_ws_valid  out  1  output valid
ms_to_ws_bus  out  PC_W+REG_ADDR_W+33  {gr_we, dest, final_result[31:0], pc}
data_sram_data_ok  in  1  one-cycle pulse: response for the outstanding request
data_sram_rdata  in  32  response data, valid with data_ok
ms_to_ds_bus  out  REG_ADDR_W+34  {ld_pending, ds_we, dest, final_result[31:0]}

Behaviour:
- Registers: ms_valid, bus_r, rdata_buf, resp_got. Reset clears ms_valid and resp_got. All outputs are derived from these, so after reset ms_to_ws_valid=0, ds_we=0, ld_pending=0 and ms_allowin=1.
- Accept: ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). When ms_allowin, ms_valid <= es_to_ms_valid. bus_r loads only when es_to_ms_valid && ms_allowin.
- A new instruction entering clears resp_got.
- ms_ready_go = !mem_req_r || resp_got || data_sram_data_ok.
- Response capture: data_ok while ms_valid && mem_req_r && !resp_got sets resp_got and loads rdata_buf (HOLD_RDATA=1). Data is used the same cycle via bypass.
  - If ws_allowin=1 that cycle, the instruction advances with zero added latency.
  - Otherwise it holds, using rdata_buf.
- Stray data_ok (ms_valid=0, mem_req_r=0, or resp_got=1) is a protocol error, ignored in the default build.
- States:
  - EMPTY: !ms_valid.
  - WAIT: ms_valid && mem_req_r && !resp_got.
  - READY: otherwise.
  - Transitions: EMPTY->WAIT/READY on accept. WAIT->READY on data_ok. READY->EMPTY/WAIT/READY on advance, depending on the incoming instruction.
- Load extraction: raw = resp_got ? rdata_buf : data_sram_rdata; off = alu_result_r[1:0].
  - ld_op 000 lw: raw.
  - 001 lb: sign-extend raw[8*off+7 : 8*off].
  - 010 lbu: zero-extend the same byte.
  - 011 lh: sign-extend raw[16*off[1]+15 : 16*off[1]].
  - 100 lhu: zero-extend the same halfword.
  - 101-111: treated as lw.
  - Alignment is not checked here.
- final_result = res_from_mem_r ? extracted : alu_result_r.
- Forwarding:
  - ds_we = ms_valid && gr_we_r.
  - ld_pending = ms_valid && res_from_mem_r && !ms_ready_go.
  - final_result on the forwarding bus is meaningful only when ld_pending=0.
- Reset mid-WAIT: the stage empties. The external bus is reset in the same cycle, so no late response arrives.

Optional Feature:
MEM_STAGE_FLUSH_EN adds input ms_flush (1 bit, exception/branch flush).
- Effects in the cycle ms_flush=1:
  - ms_valid <= 0 and no accept occurs that cycle.
  - If the stage was in WAIT with no data_ok that cycle, a discard flag is set.
- While the discard flag is set, the next data_ok is dropped and clears the flag. The stage may accept a new instruction meanwhile, but that instruction cannot see the dropped data_ok as its own response.
- Any stray data_ok is silently dropped.
- Without the macro: no port, no discard flag.

Test Plan:
- ALU op, mem_req=0, alu_result=0x12345678, ws_allowin=1 -> ms_to_ws_valid next cycle, final_result=0x12345678, 1-cycle occupancy.
- lb, off=2, data_ok after 3 cycles, rdata=0x00_80_00_00 -> ld_pending=1 for 3 cycles, then final_result=0xFFFFFF80, advances in the data_ok cycle.
- lhu, off=2, rdata=0xBEEF0000, ws_allowin=0 for 4 cycles after data_ok, data bus driven to 0 afterwards -> final_result holds 0x0000BEEF from rdata_buf, ms_allowin=0 until ws_allowin=1.
- Back-to-back lw (rdata 0x11111111, then 0x22222222) with ws_allowin=1 -> two ws transfers in consecutive data_ok cycles with the correct order and no loss.
- Reset asserted while in WAIT -> next cycle ms_valid=0, ms_to_ws_valid=0, ld_pending=0, ms_allowin=1.
- (MEM_STAGE_FLUSH_EN) flush in WAIT, new lw accepted, then old data_ok=0xDEAD then new data_ok=0xCAFE -> only 0x0000CAFE written back.
